pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/pipeline_ctrl_hazard.sv | 16 +
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control slice: controller states,
// the default memory timeout, the bubble pattern and decoder opcodes.
package pipeline_pkg;

   localparam int REG_ADDR_W          = 5;
   localparam int MEM_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } pipe_state_e;

   // Control bits carried by a stage register; a bubble has every bit cleared
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic       mem_to_reg;
      logic [1:0] alu_op;
   } ctrl_bits_t;

   localparam ctrl_bits_t BUBBLE = '0;

   // RV32I major opcodes recognised by the decoder
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard detection: a load in EX writing a register that the
// instruction in ID reads. Register x0 never creates a dependency.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   output logic                  load_use
);

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller. Stage enables and flushes are decoded
// combinationally from the current state and inputs so a hazard stalls the
// pipe in the same cycle it is seen. A memory access that does not complete
// freezes every stage until dmem_ready, and a wait that runs too long locks
// the controller in ERROR until reset.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  halt_err,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   pipe_state_e        state_q, state_d, eff_state;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               load_use;
   logic               mem_stall;
   logic               freeze;

   hazard_detect u_hazard (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .load_use    (load_use)
   );

   assign mem_stall = mem_req && !dmem_ready;
   assign stall_cnt = stall_cnt_q;

   // Next state, wait counter and stage controls; while in reset the outputs decode as RUN
   always_comb begin
      eff_state    = rst_n ? state_q : ST_RUN;
      state_d      = state_q;
      wait_d       = wait_q;
      freeze       = 1'b0;
      halt_err     = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;

      case (eff_state)
         ST_RUN: begin
            freeze = mem_stall;
            if (mem_stall) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_ONE;
            end
         end
         ST_MEM_WAIT: begin
            freeze = !dmem_ready;
            if (!dmem_ready) begin
               if (wait_q == WAIT_MAX) begin
                  state_d = ST_ERROR;
               end else begin
                  wait_d = wait_q + WAIT_ONE;
               end
            end else begin
               state_d = ST_RUN;
               wait_d  = '0;
            end
         end
         ST_ERROR: begin
            freeze   = 1'b1;
            halt_err = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            wait_d  = '0;
         end
      endcase

      if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State, wait counter and saturating stall counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wait_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Two instances share one set of
// inputs: one with default parameters and one with a short timeout and a
// 4-bit stall counter. A behavioural model tracks each instance.
module tb_pipeline_ctrl;

   // Control word order: {pc, if_id_w, id_ex_w, ex_mem_w, if_id_fl, id_ex_fl, halt}
   localparam logic [6:0] NORMAL = 7'b1111000;
   localparam logic [6:0] BRFL   = 7'b1111110;
   localparam logic [6:0] LU     = 7'b0011010;
   localparam logic [6:0] FRZ    = 7'b0000000;
   localparam logic [6:0] ERR    = 7'b0000001;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       mq;
      logic       dr;
   } stim_t;

   typedef struct {
      string      name;
      stim_t      s;
      logic [6:0] expCtl;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       ex_mem_read, ex_branch_taken, mem_req, dmem_ready;

   logic       aPc, aIfIdW, aIdExW, aExMemW, aIfIdFl, aIdExFl, aHalt;
   logic [15:0] aCnt;
   logic       bPc, bIfIdW, bIdExW, bExMemW, bIfIdFl, bIdExFl, bHalt;
   logic [3:0] bCnt;

   logic [6:0] aCtl, bCtl;
   assign aCtl = {aPc, aIfIdW, aIdExW, aExMemW, aIfIdFl, aIdExFl, aHalt};
   assign bCtl = {bPc, bIfIdW, bIdExW, bExMemW, bIfIdFl, bIdExFl, bHalt};

   int total = 0;
   int bad   = 0;

   int mWait   [2];
   bit mErr    [2];
   int mStalls [2];
   int tmo     [2] = '{255, 4};
   int cmax    [2] = '{65535, 15};

   logic [6:0] lastA, lastB;
   int         lastCntA, lastCntB;

   vec_t vecs [$];

   always #5 clk = ~clk;

   pipeline_ctrl dut_a (
      .clk (clk), .rst_n (rst_n),
      .id_rs1 (id_rs1), .id_rs2 (id_rs2), .ex_rd (ex_rd),
      .ex_mem_read (ex_mem_read), .ex_branch_taken (ex_branch_taken),
      .mem_req (mem_req), .dmem_ready (dmem_ready),
      .pc_write (aPc), .if_id_write (aIfIdW), .id_ex_write (aIdExW),
      .ex_mem_write (aExMemW), .if_id_flush (aIfIdFl), .id_ex_flush (aIdExFl),
      .halt_err (aHalt), .stall_cnt (aCnt)
   );

   pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
      .clk (clk), .rst_n (rst_n),
      .id_rs1 (id_rs1), .id_rs2 (id_rs2), .ex_rd (ex_rd),
      .ex_mem_read (ex_mem_read), .ex_branch_taken (ex_branch_taken),
      .mem_req (mem_req), .dmem_ready (dmem_ready),
      .pc_write (bPc), .if_id_write (bIfIdW), .id_ex_write (bIdExW),
      .ex_mem_write (bExMemW), .if_id_flush (bIfIdFl), .id_ex_flush (bIdExFl),
      .halt_err (bHalt), .stall_cnt (bCnt)
   );

   // Expected control word for instance k from the behavioural rules
   function automatic logic [6:0] modelCtl(input int k);
      bit waiting, freeze, lu;
      if (rst_n && mErr[k]) return ERR;
      waiting = rst_n && (mWait[k] > 0);
      freeze  = waiting ? !dmem_ready : (mem_req && !dmem_ready);
      lu      = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
      if (freeze)          return FRZ;
      if (ex_branch_taken) return BRFL;
      if (lu)              return LU;
      return NORMAL;
   endfunction

   // Advance the model of instance k across one rising edge
   function automatic void modelEdge(input int k, input logic pcW);
      if (!rst_n) begin
         mWait[k] = 0; mErr[k] = 0; mStalls[k] = 0;
      end else begin
         if (!pcW && mStalls[k] < cmax[k]) mStalls[k]++;
         if (mErr[k]) begin
         end else if (mWait[k] > 0) begin
            if (dmem_ready)            mWait[k] = 0;
            else if (mWait[k] == tmo[k]) mErr[k] = 1;
            else                       mWait[k]++;
         end else if (mem_req && !dmem_ready) begin
            mWait[k] = 1;
         end
      end
   endfunction

   task automatic checkValue(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
      ex_mem_read = s.mr; ex_branch_taken = s.br;
      mem_req = s.mq; dmem_ready = s.dr;
   endtask

   // Compare both instances to the model mid-cycle, then cross the next edge
   task automatic checkOutput(input string tag);
      logic [6:0] expA, expB;
      @(negedge clk);
      expA = modelCtl(0);
      expB = modelCtl(1);
      lastA = aCtl; lastB = bCtl;
      lastCntA = int'(aCnt); lastCntB = int'(bCnt);
      checkValue({tag, "/a_ctl"}, int'(lastA), int'(expA));
      checkValue({tag, "/b_ctl"}, int'(lastB), int'(expB));
      checkValue({tag, "/a_cnt"}, lastCntA, mStalls[0]);
      checkValue({tag, "/b_cnt"}, lastCntB, mStalls[1]);
      @(posedge clk);
      modelEdge(0, expA[6]);
      modelEdge(1, expB[6]);
      #1;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      checkOutput("reset");
      rst_n = 1'b1;
   endtask

   function automatic stim_t mk(input int rs1, input int rs2, input int rd,
                                input bit mr, input bit br, input bit mq, input bit dr);
      stim_t s;
      s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
      s.mr = mr; s.br = br; s.mq = mq; s.dr = dr;
      return s;
   endfunction

   initial begin
      stim_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 1);

      vecs.push_back('{"idle",          mk(0, 0, 0, 0, 0, 0, 0),     NORMAL});
      vecs.push_back('{"lu_rs2",        mk(1, 5, 5, 1, 0, 0, 0),     LU});
      vecs.push_back('{"lu_rs1",        mk(7, 2, 7, 1, 0, 0, 1),     LU});
      vecs.push_back('{"rd_zero",       mk(0, 0, 0, 1, 0, 0, 0),     NORMAL});
      vecs.push_back('{"no_load",       mk(9, 9, 9, 0, 0, 0, 0),     NORMAL});
      vecs.push_back('{"no_match",      mk(4, 5, 3, 1, 0, 0, 0),     NORMAL});
      vecs.push_back('{"br_over_lu",    mk(6, 1, 6, 1, 1, 0, 0),     BRFL});
      vecs.push_back('{"br_only",       mk(0, 0, 0, 0, 1, 0, 1),     BRFL});
      vecs.push_back('{"mem_done_lu",   mk(2, 8, 8, 1, 0, 1, 1),     LU});
      vecs.push_back('{"lu_r31",        mk(31, 31, 31, 1, 0, 0, 0),  LU});
      vecs.push_back('{"near_miss",     mk(30, 29, 31, 1, 0, 0, 0),  NORMAL});

      // Initial reset before any checking: registers are unknown until the first edge
      applyStimulus(idle);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         mWait[k] = 0; mErr[k] = 0; mStalls[k] = 0;
      end

      checkOutput("post_reset");
      checkValue("reset_ctl", int'(lastA), int'(NORMAL));
      checkValue("reset_cnt", lastCntA, 0);

      // Table vectors, all applied in RUN without a memory stall
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].s);
         checkOutput(vecs[i].name);
         checkValue({vecs[i].name, "/tbl_a"}, int'(lastA), int'(vecs[i].expCtl));
         checkValue({vecs[i].name, "/tbl_b"}, int'(lastB), int'(vecs[i].expCtl));
      end

      // Single-cycle load-use bubble
      resetDut();
      applyStimulus(mk(0, 5, 5, 1, 0, 0, 0));
      checkOutput("lu1");
      checkValue("lu1_ctl", int'(lastA), int'(LU));
      applyStimulus(idle);
      checkOutput("lu1_after");
      checkValue("lu1_after_ctl", int'(lastA), int'(NORMAL));
      checkValue("lu1_cnt", lastCntA, 1);

      // Memory wait of three frozen cycles with a branch held in EX
      resetDut();
      applyStimulus(mk(0, 0, 0, 0, 1, 1, 0));
      for (int i = 0; i < 3; i++) begin
         checkOutput("memwait");
         checkValue("memwait_frozen", int'(lastA), int'(FRZ));
      end
      applyStimulus(mk(0, 0, 0, 0, 1, 1, 1));
      checkOutput("memwait_done");
      checkValue("memwait_flush", int'(lastA), int'(BRFL));
      applyStimulus(idle);
      checkOutput("memwait_run");
      checkValue("memwait_run_ctl", int'(lastA), int'(NORMAL));
      checkValue("memwait_cnt", lastCntA, 3);

      // Timeout on the short-timeout instance, sticky error, then reset recovery
      resetDut();
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 5; i++) begin
         checkOutput("tmo_wait");
         checkValue("tmo_wait_b", int'(lastB), int'(FRZ));
      end
      checkOutput("tmo_err");
      checkValue("tmo_err_b", int'(lastB), int'(ERR));
      applyStimulus(idle);
      checkOutput("tmo_sticky");
      checkValue("tmo_sticky_b", int'(lastB), int'(ERR));
      checkValue("tmo_err_cnt", lastCntB, 6);
      rst_n = 1'b0;
      checkOutput("tmo_in_reset");
      checkValue("tmo_in_reset_b", int'(lastB), int'(NORMAL));
      rst_n = 1'b1;
      checkOutput("tmo_cleared");
      checkValue("tmo_cleared_b", int'(lastB), int'(NORMAL));
      checkValue("tmo_cleared_cnt", lastCntB, 0);

      // Twenty stall cycles saturate the 4-bit counter
      resetDut();
      applyStimulus(mk(3, 0, 3, 1, 0, 0, 0));
      repeat (20) checkOutput("sat");
      applyStimulus(idle);
      checkOutput("sat_end");
      checkValue("sat_cnt_b", lastCntB, 15);
      checkValue("sat_cnt_a", lastCntA, 20);

      // Randomized traffic against the model, with occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         applyStimulus(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0)));
         checkOutput("rand");
      end
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
